// File: rtl/vote_seq_n.sv
// vote_seq_n: registered bitwise majority voter over N_IN redundant channels.
// Each channel that keeps disagreeing with the voted word for ERR_THRESH
// consecutive valid samples is excluded from the vote until software clears it.
// Optional feature: define VOTE_STATS_EN to add the vote_err_cnt statistics port.
module vote_seq_n #(
  parameter int N_IN       = 5,
  parameter int WIDTH      = 3,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       ch_mask,
  input  logic [N_IN-1:0]       clr_fault,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  no_quorum,
  output logic [N_IN-1:0]       mismatch,
  output logic [N_IN-1:0]       fault
`ifdef VOTE_STATS_EN
  ,
  output logic [15:0]           vote_err_cnt
`endif
);

  // One spare bit so that 2*ones never overflows when compared against A.
  localparam int AW = $clog2(N_IN + 1) + 1;

  // Per-channel health: OK (cnt=0), SUSPECT (0<cnt<ERR_THRESH), FAILED (excluded).
  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAILED  = 2'd2
  } ch_state_e;

  ch_state_e        r_state [N_IN];
  logic [CNT_W-1:0] r_cnt   [N_IN];
  logic [N_IN-1:0]  r_fault;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_no_quorum;
  logic [N_IN-1:0]  r_mismatch;

  logic [N_IN-1:0]  w_active;
  logic [AW-1:0]    w_active_cnt;
  logic [WIDTH-1:0] w_vote;
  logic [N_IN-1:0]  w_mismatch;
  logic             w_quorum;

  // Channels taking part in this sample's vote, and how many there are.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_active     = ~ch_mask & ~r_fault;
    w_active_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_active_cnt = w_active_cnt + AW'(w_active[i]);
    end
    w_quorum = (w_active_cnt != '0);
  end

  // Per-bit majority over active channels; a tie keeps the previous voted bit.
  always_comb begin
    logic [AW-1:0] ones;
    logic [AW-1:0] twice;
    w_vote = r_out_data;
    ones   = '0;
    twice  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int i = 0; i < N_IN; i++) begin
        ones = ones + AW'(w_active[i] & in_data[i*WIDTH + b]);
      end
      twice = ones << 1;
      if (twice > w_active_cnt) begin
        w_vote[b] = 1'b1;
      end else if (twice < w_active_cnt) begin
        w_vote[b] = 1'b0;
      end
    end
  end

  // Active channels whose word differs from the new voted word.
  always_comb begin
    w_mismatch = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_mismatch[i] = w_active[i] && (in_data[i*WIDTH +: WIDTH] != w_vote);
    end
  end

  // Output register: voted word, valid strobe, quorum flag and mismatch vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_no_quorum <= 1'b0;
      r_mismatch  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      r_out_valid <= in_valid;
      if (in_valid) begin
        if (w_quorum) begin
          r_out_data  <= w_vote;
          r_no_quorum <= 1'b0;
          r_mismatch  <= w_mismatch;
        end else begin
          r_no_quorum <= 1'b1;
          r_mismatch  <= '0;
        end
      end
    end
  end

  // Per-channel health FSM: consecutive-mismatch counter and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the small per-channel arrays are reset explicitly; they are control state, not data storage.
      for (int i = 0; i < N_IN; i++) begin
        r_state[i] <= ST_OK;
        r_cnt[i]   <= '0;
      end
      r_fault <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (clr_fault[i]) begin
          r_state[i] <= ST_OK;
          r_cnt[i]   <= '0;
          r_fault[i] <= 1'b0;
        end else if (in_valid && w_active[i]) begin
          case (r_state[i])
            ST_OK, ST_SUSPECT: begin
              if (w_mismatch[i]) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                if (r_cnt[i] == CNT_W'(ERR_THRESH - 1)) begin
                  r_state[i] <= ST_FAILED;
                  r_fault[i] <= 1'b1;
                end else begin
                  r_state[i] <= ST_SUSPECT;
                end
              end else begin
                r_state[i] <= ST_OK;
                r_cnt[i]   <= '0;
              end
            end
            default: begin
              r_state[i] <= r_state[i];
            end
          endcase
        end
      end
    end
  end

`ifdef VOTE_STATS_EN
  logic [15:0] r_vote_err_cnt;

  // Saturating count of quorate samples that had at least one disagreeing channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vote_err_cnt <= '0;
    end else if (&clr_fault) begin
      r_vote_err_cnt <= '0;
    end else if (in_valid && w_quorum && (|w_mismatch) && (r_vote_err_cnt != 16'hFFFF)) begin
      r_vote_err_cnt <= r_vote_err_cnt + 16'd1;
    end
  end

  assign vote_err_cnt = r_vote_err_cnt;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign no_quorum = r_no_quorum;
  assign mismatch  = r_mismatch;
  assign fault     = r_fault;

endmodule

// File: tb/tb_vote_seq_n.sv
// Directed bench for vote_seq_n (N_IN=5, WIDTH=3, ERR_THRESH=4, CNT_W=3).
module tb_vote_seq_n;

  localparam int N_IN  = 5;
  localparam int WIDTH = 3;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       ch_mask;
  logic [N_IN-1:0]       clr_fault;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  no_quorum;
  logic [N_IN-1:0]       mismatch;
  logic [N_IN-1:0]       fault;
`ifdef VOTE_STATS_EN
  logic [15:0]           vote_err_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  vote_seq_n #(.N_IN(5), .WIDTH(3), .ERR_THRESH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .ch_mask   (ch_mask),
    .clr_fault (clr_fault),
    .out_valid (out_valid),
    .out_data  (out_data),
    .no_quorum (no_quorum),
    .mismatch  (mismatch),
    .fault     (fault)
`ifdef VOTE_STATS_EN
    ,
    .vote_err_cnt (vote_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Channel 0 in the low bits.
  function automatic logic [14:0] pk(input logic [2:0] c0, input logic [2:0] c1,
                                     input logic [2:0] c2, input logic [2:0] c3,
                                     input logic [2:0] c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic [14:0] d, input logic [4:0] m,
                       input logic [4:0] c);
    in_valid  = v;
    in_data   = d;
    ch_mask   = m;
    clr_fault = c;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clr_fault = '0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 3'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data); else pass_cnt++;
    total_cnt++; if (no_quorum !== 1'b0) $display("FAIL reset_no_quorum: got %b expected 0", no_quorum); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b0) $display("FAIL reset_mismatch: got %b expected 00000", mismatch); else pass_cnt++;
    total_cnt++; if (fault !== 5'b0) $display("FAIL reset_fault: got %b expected 00000", fault); else pass_cnt++;
`ifdef VOTE_STATS_EN
    total_cnt++; if (vote_err_cnt !== 16'd0) $display("FAIL reset_stats: got %0d expected 0", vote_err_cnt); else pass_cnt++;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_vote();
    drive(1'b1, pk(5, 5, 5, 2, 7), 5'b0, 5'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL vote_out_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 3'd5) $display("FAIL vote_out_data: got %0d expected 5", out_data); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b11000) $display("FAIL vote_mismatch: got %b expected 11000", mismatch); else pass_cnt++;
    drive(1'b0, pk(0, 0, 0, 0, 0), 5'b0, 5'b0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 3'd5) $display("FAIL hold_out_data: got %0d expected 5", out_data); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b11000) $display("FAIL hold_mismatch: got %b expected 11000", mismatch); else pass_cnt++;
  endtask

  task automatic test_tie();
    // Three active channels {3,3,4}: odd count, plain majority gives 3.
    drive(1'b1, pk(0, 0, 3, 3, 4), 5'b00011, 5'b0);
    total_cnt++; if (out_data !== 3'd3) $display("FAIL mask3_out_data: got %0d expected 3", out_data); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b10000) $display("FAIL mask3_mismatch: got %b expected 10000", mismatch); else pass_cnt++;
    drive(1'b1, pk(0, 0, 0, 0, 0), 5'b0, 5'b0);
    total_cnt++; if (out_data !== 3'd0) $display("FAIL tie_pre0: got %0d expected 0", out_data); else pass_cnt++;
    // Four active channels {3,3,4,4}: every bit ties, previous word held.
    drive(1'b1, pk(3, 3, 4, 4, 0), 5'b10000, 5'b0);
    total_cnt++; if (out_data !== 3'd0) $display("FAIL tie_hold0: got %0d expected 0", out_data); else pass_cnt++;
    drive(1'b1, pk(7, 7, 7, 7, 7), 5'b0, 5'b0);
    total_cnt++; if (out_data !== 3'd7) $display("FAIL tie_pre7: got %0d expected 7", out_data); else pass_cnt++;
    drive(1'b1, pk(3, 3, 4, 4, 0), 5'b10000, 5'b0);
    total_cnt++; if (out_data !== 3'd7) $display("FAIL tie_hold7: got %0d expected 7", out_data); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b01111) $display("FAIL tie_mismatch: got %b expected 01111", mismatch); else pass_cnt++;
    drive(1'b1, pk(0, 0, 0, 0, 0), 5'b0, 5'b0);
    total_cnt++; if (fault !== 5'b0) $display("FAIL tie_fault: got %b expected 00000", fault); else pass_cnt++;
  endtask

  task automatic test_no_quorum();
    drive(1'b1, pk(6, 6, 6, 6, 6), 5'b0, 5'b0);
    drive(1'b1, pk(1, 1, 1, 1, 1), 5'b11111, 5'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL nq_out_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (no_quorum !== 1'b1) $display("FAIL nq_flag: got %b expected 1", no_quorum); else pass_cnt++;
    total_cnt++; if (out_data !== 3'd6) $display("FAIL nq_out_data: got %0d expected 6", out_data); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b0) $display("FAIL nq_mismatch: got %b expected 00000", mismatch); else pass_cnt++;
    drive(1'b1, pk(2, 2, 2, 2, 2), 5'b0, 5'b0);
    total_cnt++; if (no_quorum !== 1'b0) $display("FAIL nq_clear: got %b expected 0", no_quorum); else pass_cnt++;
    total_cnt++; if (out_data !== 3'd2) $display("FAIL nq_after_data: got %0d expected 2", out_data); else pass_cnt++;
  endtask

  task automatic test_fault();
    for (int k = 0; k < 3; k++) drive(1'b1, pk(5, 5, 5, 5, 2), 5'b0, 5'b0);
    total_cnt++; if (mismatch !== 5'b10000) $display("FAIL flt_mismatch3: got %b expected 10000", mismatch); else pass_cnt++;
    total_cnt++; if (fault !== 5'b0) $display("FAIL flt_after3: got %b expected 00000", fault); else pass_cnt++;
    // A matching sample breaks the run, so three more mismatches do not fault.
    drive(1'b1, pk(5, 5, 5, 5, 5), 5'b0, 5'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, pk(5, 5, 5, 5, 2), 5'b0, 5'b0);
    total_cnt++; if (fault !== 5'b0) $display("FAIL flt_consecutive: got %b expected 00000", fault); else pass_cnt++;
    drive(1'b1, pk(5, 5, 5, 5, 2), 5'b0, 5'b0);
    total_cnt++; if (fault !== 5'b10000) $display("FAIL flt_set: got %b expected 10000", fault); else pass_cnt++;
    // Channel 4 now excluded: {7,7,0,0} ties on every bit, previous 5 held.
    drive(1'b1, pk(7, 7, 0, 0, 7), 5'b0, 5'b0);
    total_cnt++; if (out_data !== 3'd5) $display("FAIL flt_excluded_data: got %0d expected 5", out_data); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b01111) $display("FAIL flt_excluded_mm: got %b expected 01111", mismatch); else pass_cnt++;
    total_cnt++; if (fault !== 5'b10000) $display("FAIL flt_sticky: got %b expected 10000", fault); else pass_cnt++;
    drive(1'b0, pk(0, 0, 0, 0, 0), 5'b0, 5'b10000);
    total_cnt++; if (fault !== 5'b0) $display("FAIL flt_clear: got %b expected 00000", fault); else pass_cnt++;
    drive(1'b1, pk(5, 5, 5, 5, 5), 5'b0, 5'b0);
  endtask

  task automatic test_clr_fault();
    for (int k = 0; k < 3; k++) drive(1'b1, pk(5, 5, 5, 5, 2), 5'b0, 5'b0);
    drive(1'b1, pk(5, 5, 5, 5, 2), 5'b0, 5'b10000);
    total_cnt++; if (fault !== 5'b0) $display("FAIL clr_wins: got %b expected 00000", fault); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b10000) $display("FAIL clr_mismatch: got %b expected 10000", mismatch); else pass_cnt++;
    for (int k = 0; k < 3; k++) drive(1'b1, pk(5, 5, 5, 5, 2), 5'b0, 5'b0);
    total_cnt++; if (fault !== 5'b0) $display("FAIL clr_cnt_zeroed: got %b expected 00000", fault); else pass_cnt++;
    drive(1'b1, pk(5, 5, 5, 5, 2), 5'b0, 5'b0);
    total_cnt++; if (fault !== 5'b10000) $display("FAIL clr_refault: got %b expected 10000", fault); else pass_cnt++;
    drive(1'b0, pk(0, 0, 0, 0, 0), 5'b0, 5'b10000);
    drive(1'b1, pk(5, 5, 5, 5, 5), 5'b0, 5'b0);
  endtask

  task automatic test_back_to_back();
    logic [14:0] vec [4];
    logic [2:0]  exp_d [4];
    logic [4:0]  exp_m [4];
    vec[0] = pk(1, 1, 1, 0, 0); exp_d[0] = 3'd1; exp_m[0] = 5'b11000;
    vec[1] = pk(6, 6, 2, 6, 4); exp_d[1] = 3'd6; exp_m[1] = 5'b10100;
    vec[2] = pk(3, 7, 3, 1, 3); exp_d[2] = 3'd3; exp_m[2] = 5'b01010;
    vec[3] = pk(4, 4, 4, 4, 4); exp_d[3] = 3'd4; exp_m[3] = 5'b00000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, vec[k], 5'b0, 5'b0);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b expected 1", k, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== exp_d[k]) $display("FAIL b2b_data[%0d]: got %0d expected %0d", k, out_data, exp_d[k]); else pass_cnt++;
      total_cnt++; if (mismatch !== exp_m[k]) $display("FAIL b2b_mismatch[%0d]: got %b expected %b", k, mismatch, exp_m[k]); else pass_cnt++;
    end
  endtask

`ifdef VOTE_STATS_EN
  task automatic test_stats();
    drive(1'b0, pk(0, 0, 0, 0, 0), 5'b0, 5'b11111);
    total_cnt++; if (vote_err_cnt !== 16'd0) $display("FAIL stats_clear: got %0d expected 0", vote_err_cnt); else pass_cnt++;
    for (int k = 0; k < 3; k++) drive(1'b1, pk(4, 4, 4, 4, 0), 5'b0, 5'b0);
    for (int k = 0; k < 2; k++) drive(1'b1, pk(4, 4, 4, 4, 4), 5'b0, 5'b0);
    total_cnt++; if (vote_err_cnt !== 16'd3) $display("FAIL stats_count: got %0d expected 3", vote_err_cnt); else pass_cnt++;
  endtask
`endif

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, pk(4, 4, 4, 4, 1), 5'b0, 5'b0);
    total_cnt++; if (fault !== 5'b10000) $display("FAIL ar_prefault: got %b expected 10000", fault); else pass_cnt++;
    in_valid = 1'b1;
    in_data  = pk(2, 2, 2, 2, 2);
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 3'd0) $display("FAIL ar_out_data: got %0d expected 0", out_data); else pass_cnt++;
    total_cnt++; if (mismatch !== 5'b0) $display("FAIL ar_mismatch: got %b expected 00000", mismatch); else pass_cnt++;
    total_cnt++; if (fault !== 5'b0) $display("FAIL ar_fault: got %b expected 00000", fault); else pass_cnt++;
`ifdef VOTE_STATS_EN
    total_cnt++; if (vote_err_cnt !== 16'd0) $display("FAIL ar_stats: got %0d expected 0", vote_err_cnt); else pass_cnt++;
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, pk(2, 2, 2, 2, 2), 5'b0, 5'b0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_no_output: got %b expected 0", out_valid); else pass_cnt++;
    drive(1'b1, pk(6, 6, 6, 1, 1), 5'b0, 5'b0);
    total_cnt++; if (out_data !== 3'd6) $display("FAIL ar_resume: got %0d expected 6", out_data); else pass_cnt++;
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ch_mask   = '0;
    clr_fault = '0;
    test_reset();
    test_vote();
    test_tie();
    test_no_quorum();
    test_fault();
    test_clr_fault();
    test_back_to_back();
`ifdef VOTE_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
